d_jb_predict: RTL and testbench

Decode-stage jump/branch controller with prediction state for the pipelined MIPS core. It performs the full branch/jump decode, adding blez/bgtz/bltz/bgez and jalr. It predicts conditional branches with a parametrised table of 2-bit saturating counters, and predicts `jr $ra` targets with a parametrised return-address stack (RAS). The execute stage returns resolved branch outcomes, which train the table and raise a registered mispredict flag for the fetch/flush logic.

---
 rtl/d_jb_predict_if.sv | 41 ++++
 rtl/d_jb_predict.sv | 140 ++++++++++++++
 tb/tb_d_jb_predict.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/d_jb_predict_if.sv
// Decode/execute-side bus of the jump/branch predictor: the decode instruction fields,
// the resolved-branch update from execute, and the decode/prediction results.
interface d_jb_predict_if #(
    parameter int unsigned PC_W = 32
);
    logic            i_con_valid;
    logic            i_con_stall;
    logic            i_con_flush;
    logic [5:0]      i_con_instru;
    logic [5:0]      i_con_func;
    logic            i_con_rt;
    logic            i_con_rs_ra;
    logic [PC_W-1:0] i_con_pc;
    logic [1:0]      o_con_jump;
    logic [2:0]      o_con_bop;
    logic            o_con_aluPC4;
    logic            o_con_pred_taken;
    logic            o_con_ras_hit;
    logic [PC_W-1:0] o_con_ras_addr;
    logic            i_ex_upd_valid;
    logic [PC_W-1:0] i_ex_upd_pc;
    logic            i_ex_upd_taken;
    logic            i_ex_upd_pred;
    logic            o_con_mispredict;

    modport master (
        output i_con_valid, i_con_stall, i_con_flush, i_con_instru, i_con_func,
               i_con_rt, i_con_rs_ra, i_con_pc,
               i_ex_upd_valid, i_ex_upd_pc, i_ex_upd_taken, i_ex_upd_pred,
        input  o_con_jump, o_con_bop, o_con_aluPC4, o_con_pred_taken,
               o_con_ras_hit, o_con_ras_addr, o_con_mispredict
    );

    modport slave (
        input  i_con_valid, i_con_stall, i_con_flush, i_con_instru, i_con_func,
               i_con_rt, i_con_rs_ra, i_con_pc,
               i_ex_upd_valid, i_ex_upd_pc, i_ex_upd_taken, i_ex_upd_pred,
        output o_con_jump, o_con_bop, o_con_aluPC4, o_con_pred_taken,
               o_con_ras_hit, o_con_ras_addr, o_con_mispredict
    );
endinterface

// File: rtl/d_jb_predict.sv
// Decode-stage jump/branch decode with a 2-bit-counter branch history table,
// a circular return-address stack for jr $ra, and a registered mispredict flag.
module d_jb_predict #(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned RAS_DEPTH = 4
) (
    input logic           i_clk,
    input logic           i_rst_n,
    d_jb_predict_if.slave bus
);
    localparam int unsigned BHT_N = 1 << IDX_W;
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [1:0]      jump_c;
    logic [2:0]      bop_c;
    logic            pc4_c;
    logic            is_jr_c;
    logic            is_link_c;
    logic            accept_c;
    logic            push_c;
    logic            pop_c;

    logic [1:0]      bht_q [BHT_N];
    logic [1:0]      upd_ctr_c;
    logic [IDX_W-1:0] rd_idx_c;
    logic [IDX_W-1:0] wr_idx_c;

    logic [PC_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            mispredict_q, mispredict_d;
    logic            unused_pc_bits;

    // Instruction decode; independent of i_con_valid.
    always_comb begin
        jump_c    = 2'b00;
        bop_c     = 3'b000;
        pc4_c     = 1'b0;
        is_jr_c   = 1'b0;
        is_link_c = 1'b0;
        case (bus.i_con_instru)
            6'b000100: bop_c = 3'd1;
            6'b000101: bop_c = 3'd2;
            6'b000110: bop_c = 3'd3;
            6'b000111: bop_c = 3'd4;
            6'b000001: bop_c = bus.i_con_rt ? 3'd6 : 3'd5;
            6'b000010: jump_c = 2'b01;
            6'b000011: begin
                jump_c    = 2'b01;
                pc4_c     = 1'b1;
                is_link_c = 1'b1;
            end
            6'b000000: begin
                case (bus.i_con_func)
                    6'b001000: begin
                        jump_c  = 2'b10;
                        is_jr_c = 1'b1;
                    end
                    6'b001001: begin
                        jump_c    = 2'b10;
                        pc4_c     = 1'b1;
                        is_link_c = 1'b1;
                    end
                    default: jump_c = 2'b11;
                endcase
            end
            default: ;
        endcase
    end

    assign accept_c = bus.i_con_valid & ~bus.i_con_stall & ~bus.i_con_flush;
    assign push_c   = accept_c & is_link_c;
    assign pop_c    = accept_c & is_jr_c & bus.i_con_rs_ra & (cnt_q != '0);

    assign rd_idx_c = bus.i_con_pc[IDX_W+1:2];
    assign wr_idx_c = bus.i_ex_upd_pc[IDX_W+1:2];

    // Saturating counter step for the entry being trained.
    always_comb begin
        upd_ctr_c = bht_q[wr_idx_c];
        if (bus.i_ex_upd_taken) begin
            if (bht_q[wr_idx_c] != 2'b11) upd_ctr_c = bht_q[wr_idx_c] + 2'd1;
        end else begin
            if (bht_q[wr_idx_c] != 2'b00) upd_ctr_c = bht_q[wr_idx_c] - 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(BHT_N); i++) bht_q[i] <= 2'b01;
        end else if (bus.i_ex_upd_valid) begin
            bht_q[wr_idx_c] <= upd_ctr_c;
        end
    end

    // Full push advances onto the oldest slot, so overflow overwrites it naturally.
    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        if (push_c) begin
            top_d = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_c) begin
            top_d = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            top_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            if (push_c) ras_q[top_d] <= bus.i_con_pc + PC_W'(4);
        end
    end

    assign mispredict_d = bus.i_ex_upd_valid & (bus.i_ex_upd_taken ^ bus.i_ex_upd_pred);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) mispredict_q <= 1'b0;
        else          mispredict_q <= mispredict_d;
    end

    assign bus.o_con_jump       = jump_c;
    assign bus.o_con_bop        = bop_c;
    assign bus.o_con_aluPC4     = pc4_c;
    assign bus.o_con_pred_taken = (bop_c != 3'b000) & bht_q[rd_idx_c][1];
    assign bus.o_con_ras_hit    = is_jr_c & bus.i_con_rs_ra & (cnt_q != '0);
    assign bus.o_con_ras_addr   = (cnt_q != '0) ? ras_q[top_q] : '0;
    assign bus.o_con_mispredict = mispredict_q;

    assign unused_pc_bits = ^{bus.i_ex_upd_pc[PC_W-1:IDX_W+2], bus.i_ex_upd_pc[1:0],
                              bus.i_con_pc[1:0]};
endmodule

// File: tb/tb_d_jb_predict.sv
// Scoreboard bench for d_jb_predict: expectations are queued with the stimulus and
// drained against the DUT on the falling edge of the same cycle.
module tb_d_jb_predict;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    d_jb_predict_if #(.PC_W(32)) bus ();

    d_jb_predict #(.PC_W(32), .IDX_W(6), .RAS_DEPTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    string       phase = "init";
    string       tag_q[$];
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got 0x%0h want 0x%0h", phase, tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sig(input string t);
        if (t == "jump")      return 32'(bus.o_con_jump);
        else if (t == "bop")  return 32'(bus.o_con_bop);
        else if (t == "pc4")  return 32'(bus.o_con_aluPC4);
        else if (t == "pred") return 32'(bus.o_con_pred_taken);
        else if (t == "hit")  return 32'(bus.o_con_ras_hit);
        else if (t == "addr") return bus.o_con_ras_addr;
        else if (t == "misp") return 32'(bus.o_con_mispredict);
        return 32'hDEAD_BEEF;
    endfunction

    task automatic sb_push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    // One clock: drain the scoreboard mid-cycle, then take the edge.
    task automatic cyc();
        string       t;
        logic [31:0] e;
        @(negedge clk);
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            chk(t, sig(t), e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic rt,
                         input logic ra, input logic [31:0] pc, input logic v);
        bus.i_con_instru = op;
        bus.i_con_func   = fn;
        bus.i_con_rt     = rt;
        bus.i_con_rs_ra  = ra;
        bus.i_con_pc     = pc;
        bus.i_con_valid  = v;
        bus.i_con_stall  = 1'b0;
        bus.i_con_flush  = 1'b0;
    endtask

    task automatic upd(input logic v, input logic [31:0] pc, input logic tk, input logic pr);
        bus.i_ex_upd_valid = v;
        bus.i_ex_upd_pc    = pc;
        bus.i_ex_upd_taken = tk;
        bus.i_ex_upd_pred  = pr;
    endtask

    task automatic idle();
        instr(6'b100011, 6'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        upd(1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    localparam logic [5:0] OP_R = 6'b000000, OP_JAL = 6'b000011, OP_BEQ = 6'b000100;
    localparam logic [5:0] FN_JR = 6'b001000, FN_JALR = 6'b001001;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rt;
        logic [1:0] jump;
        logic [2:0] bop;
        logic       pc4;
    } dec_t;

    dec_t dec_tbl[$];

    initial begin
        dec_tbl = '{
            '{6'b000001, 6'd0,     1'b1, 2'b00, 3'd6, 1'b0},
            '{6'b000001, 6'd0,     1'b0, 2'b00, 3'd5, 1'b0},
            '{OP_R,      FN_JALR,  1'b0, 2'b10, 3'd0, 1'b1},
            '{OP_R,      FN_JR,    1'b0, 2'b10, 3'd0, 1'b0},
            '{OP_R,      6'b100000,1'b0, 2'b11, 3'd0, 1'b0},
            '{6'b000110, 6'd0,     1'b0, 2'b00, 3'd3, 1'b0},
            '{6'b000111, 6'd0,     1'b0, 2'b00, 3'd4, 1'b0},
            '{6'b000101, 6'd0,     1'b0, 2'b00, 3'd2, 1'b0},
            '{OP_BEQ,    6'd0,     1'b0, 2'b00, 3'd1, 1'b0},
            '{6'b000010, 6'd0,     1'b0, 2'b01, 3'd0, 1'b0},
            '{OP_JAL,    6'd0,     1'b0, 2'b01, 3'd0, 1'b1},
            '{6'b100011, 6'd0,     1'b0, 2'b00, 3'd0, 1'b0}
        };

        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        phase = "reset";
        instr(OP_BEQ, 6'd0, 1'b0, 1'b0, 32'h40, 1'b0);
        sb_push("pred", 0); sb_push("misp", 0);
        cyc();
        instr(OP_R, FN_JR, 1'b0, 1'b1, 32'h0, 1'b0);
        sb_push("hit", 0); sb_push("addr", 0);
        cyc();

        // Decode sweep with valid low so link instructions leave the RAS alone.
        phase = "decode";
        foreach (dec_tbl[i]) begin
            instr(dec_tbl[i].op, dec_tbl[i].fn, dec_tbl[i].rt, 1'b0, 32'h1000, 1'b0);
            sb_push("jump", 32'(dec_tbl[i].jump));
            sb_push("bop",  32'(dec_tbl[i].bop));
            sb_push("pc4",  32'(dec_tbl[i].pc4));
            if (dec_tbl[i].op == 6'b100011) sb_push("pred", 0);
            cyc();
        end

        phase = "bht";
        instr(OP_BEQ, 6'd0, 1'b0, 1'b0, 32'h40, 1'b0);
        upd(1'b1, 32'h40, 1'b1, 1'b0);
        sb_push("pred", 0);
        cyc();
        upd(1'b0, 32'h0, 1'b0, 1'b0);
        sb_push("pred", 1); sb_push("misp", 1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            upd(1'b1, 32'h40, 1'b1, 1'b1);
            sb_push("pred", 1);
            cyc();
        end
        upd(1'b1, 32'h40, 1'b0, 1'b1);
        sb_push("pred", 1); sb_push("misp", 0);
        cyc();
        upd(1'b0, 32'h0, 1'b0, 1'b0);
        sb_push("pred", 1); sb_push("misp", 1);
        cyc();
        upd(1'b1, 32'h40, 1'b0, 1'b0);
        sb_push("pred", 1);
        cyc();
        upd(1'b0, 32'h0, 1'b0, 1'b0);
        sb_push("pred", 0); sb_push("misp", 0);
        cyc();
        instr(6'b100011, 6'd0, 1'b0, 1'b0, 32'h40, 1'b0);
        sb_push("pred", 0);
        cyc();

        phase = "misp";
        upd(1'b1, 32'h80, 1'b1, 1'b0);
        cyc();
        upd(1'b0, 32'h0, 1'b0, 1'b0);
        sb_push("misp", 1);
        cyc();
        sb_push("misp", 0);
        cyc();
        upd(1'b1, 32'h80, 1'b1, 1'b1);
        cyc();
        upd(1'b1, 32'h80, 1'b0, 1'b1);
        sb_push("misp", 0);
        cyc();
        upd(1'b0, 32'h0, 1'b0, 1'b0);
        sb_push("misp", 1);
        cyc();
        sb_push("misp", 0);
        cyc();

        phase = "ras_ovf";
        for (int k = 1; k <= 5; k++) begin
            instr(OP_JAL, 6'd0, 1'b0, 1'b0, 32'(k * 32'h100), 1'b1);
            cyc();
        end
        for (int k = 5; k >= 2; k--) begin
            instr(OP_R, FN_JR, 1'b0, 1'b1, 32'h0, 1'b1);
            sb_push("hit", 1);
            sb_push("addr", 32'(k * 32'h100 + 4));
            cyc();
        end
        instr(OP_R, FN_JR, 1'b0, 1'b1, 32'h0, 1'b1);
        sb_push("hit", 0); sb_push("addr", 0);
        cyc();

        phase = "stall_flush";
        instr(OP_JAL, 6'd0, 1'b0, 1'b0, 32'h900, 1'b1);
        bus.i_con_stall = 1'b1;
        cyc();
        instr(OP_JAL, 6'd0, 1'b0, 1'b0, 32'h900, 1'b1);
        bus.i_con_flush = 1'b1;
        cyc();
        instr(OP_R, FN_JR, 1'b0, 1'b1, 32'h0, 1'b1);
        sb_push("hit", 0); sb_push("addr", 0);
        cyc();
        instr(OP_JAL, 6'd0, 1'b0, 1'b0, 32'h600, 1'b1);
        cyc();
        instr(OP_R, FN_JR, 1'b0, 1'b1, 32'h0, 1'b0);
        sb_push("hit", 1); sb_push("addr", 32'h604);
        cyc();
        instr(OP_R, FN_JALR, 1'b0, 1'b1, 32'hA00, 1'b1);
        sb_push("hit", 0); sb_push("addr", 32'h604);
        cyc();
        instr(OP_R, FN_JR, 1'b0, 1'b1, 32'h0, 1'b1);
        sb_push("hit", 1); sb_push("addr", 32'hA04);
        cyc();
        instr(OP_R, FN_JR, 1'b0, 1'b1, 32'h0, 1'b1);
        sb_push("hit", 1); sb_push("addr", 32'h604);
        cyc();
        instr(OP_R, FN_JR, 1'b0, 1'b1, 32'h0, 1'b0);
        sb_push("hit", 0); sb_push("addr", 0);
        cyc();

        phase = "mid_reset";
        upd(1'b1, 32'h14, 1'b1, 1'b1);
        instr(OP_JAL, 6'd0, 1'b0, 1'b0, 32'h700, 1'b1);
        cyc();
        instr(OP_JAL, 6'd0, 1'b0, 1'b0, 32'h800, 1'b1);
        cyc();
        upd(1'b0, 32'h0, 1'b0, 1'b0);
        instr(OP_BEQ, 6'd0, 1'b0, 1'b0, 32'h14, 1'b0);
        sb_push("pred", 1);
        cyc();
        instr(OP_R, FN_JR, 1'b0, 1'b1, 32'h0, 1'b0);
        sb_push("hit", 1); sb_push("addr", 32'h804);
        cyc();
        rst_n = 1'b0;
        upd(1'b1, 32'h20, 1'b1, 1'b0);
        instr(OP_JAL, 6'd0, 1'b0, 1'b0, 32'hB00, 1'b1);
        cyc();
        rst_n = 1'b1;
        idle();
        instr(OP_R, FN_JR, 1'b0, 1'b1, 32'h0, 1'b0);
        sb_push("hit", 0); sb_push("addr", 0); sb_push("misp", 0);
        cyc();
        for (int i = 0; i < 64; i++) begin
            instr(OP_BEQ, 6'd0, 1'b0, 1'b0, 32'(i << 2), 1'b0);
            sb_push("pred", 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
